// File: rtl/dsp_ctrl_pkg.sv
// Shared types and constants for the DSP48A1 MAC sequencing controller:
// FSM state encoding, slice OPMODE values and the per-cycle pipeline tag.
package dsp_ctrl_pkg;

    // Controller states; encoding is exposed on the dbg_state port.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RUN   = 3'd1,
        ZERO  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_e;

    // OPMODE words for the slice: X=M with Z=0 starts a sum, Z=P accumulates.
    localparam logic [7:0] OPMODE_MUL = 8'h01;
    localparam logic [7:0] OPMODE_MAC = 8'h09;

    // One tag per cycle travels alongside the operand through the slice.
    typedef struct packed {
        logic valid;
        logic first;
    } tag_t;

    localparam tag_t TAG_BUBBLE = '{valid: 1'b0, first: 1'b0};

    // OPMODE to apply when a tag reaches the P register: only the first
    // valid beat of a job clears the accumulation, everything else is MAC.
    function automatic logic [7:0] tag_opmode(input tag_t t);
        return (t.valid && t.first) ? OPMODE_MUL : OPMODE_MAC;
    endfunction

endpackage

// File: rtl/dsp_tag_pipe.sv
// Shift register of DEPTH tags that mirrors the slice pipeline between the
// operand-capture enable and the P-register load. The OPMODE word is
// registered from the tag entering the last stage so it lines up with
// valid_o in the same cycle.
module dsp_tag_pipe
    import dsp_ctrl_pkg::*;
#(
    parameter int DEPTH = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr_i,
    input  tag_t       tag_i,
    output logic       valid_o,
    output logic [7:0] opmode_o,
    output logic       upstream_busy_o
);

    tag_t       stage_q [DEPTH];
    tag_t       chain   [DEPTH];
    logic [7:0] opmode_q;

    // Next value of each stage: stage 0 takes the pushed tag, the rest shift.
    always_comb begin
        chain[0] = tag_i;
        for (int i = 1; i < DEPTH; i++) begin
            chain[i] = stage_q[i-1];
        end
    end

    // Any valid tag still ahead of the output stage means the sum is not final.
    always_comb begin
        upstream_busy_o = 1'b0;
        for (int i = 0; i < DEPTH - 1; i++) begin
            upstream_busy_o = upstream_busy_o | stage_q[i].valid;
        end
    end

    // Pipe storage: async reset, sync clear empties it, otherwise shift by one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= TAG_BUBBLE;
            end
            opmode_q <= OPMODE_MUL;
        end else if (clr_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= TAG_BUBBLE;
            end
            opmode_q <= OPMODE_MAC;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= chain[i];
            end
            opmode_q <= tag_opmode(chain[DEPTH-1]);
        end
    end

    assign valid_o  = stage_q[DEPTH-1].valid;
    assign opmode_o = opmode_q;

endmodule

// File: rtl/dsp48a1_mac_sched.sv
// Sequencing controller for a DSP48A1 slice computing P = sum(A*B) over a
// job of N operand beats. It carries no data; it drives the slice CEs,
// OPMODE and RSTP and presents the finished sum via res_valid/res_ready.
//
// Optional build macro DSP48A1_MAC_SCHED_ABORT_EN adds an 'abort' input
// that cancels a job in RUN, DRAIN or DONE without producing a result.
//
// Handshakes (start, op, res): a transfer happens in a cycle where valid and
// ready are both high; a producer holding valid high keeps it high until the
// transfer, and ready never depends combinationally on valid.
module dsp48a1_mac_sched
    import dsp_ctrl_pkg::*;
#(
    parameter int LEN_W    = 8,
    parameter int PIPE_LAT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [LEN_W-1:0] start_len,
    input  logic             op_valid,
    output logic             op_ready,
    output logic             dsp_ce_in,
    output logic             dsp_ce_p,
    output logic [7:0]       dsp_opmode,
    output logic             dsp_rst_p,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             busy,
    output logic [LEN_W-1:0] beat_cnt,
`ifdef DSP48A1_MAC_SCHED_ABORT_EN
    input  logic             abort,
`endif
    output state_e           dbg_state
);

    localparam int TAG_DEPTH = PIPE_LAT - 1;

    state_e           state_q;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] beat_cnt_q;
    logic [LEN_W-1:0] beat_cnt_d;
    logic             start_ready_q;
    logic             op_ready_q;
    logic             res_valid_q;
    logic             busy_q;
    logic             rst_p_q;

    logic             start_acc;
    logic             beat_acc;
    logic             abort_hit;
    logic             pipe_upstream_busy;
    tag_t             tag_push;

    assign start_acc = start_valid & start_ready_q;
    assign beat_acc  = op_valid & op_ready_q;

`ifdef DSP48A1_MAC_SCHED_ABORT_EN
    // Abort only acts once a job is under way; IDLE and ZERO ignore it.
    assign abort_hit = abort &&
                       ((state_q == RUN) || (state_q == DRAIN) || (state_q == DONE));
`else
    assign abort_hit = 1'b0;
`endif

    // Saturating beat counter so an extreme length never wraps back to zero.
    always_comb begin
        beat_cnt_d = beat_cnt_q;
        if (beat_cnt_q != {LEN_W{1'b1}}) begin
            beat_cnt_d = beat_cnt_q + LEN_W'(1);
        end
    end

    // Tag for this cycle: accepted beats are valid, everything else is a bubble.
    always_comb begin
        tag_push       = TAG_BUBBLE;
        tag_push.valid = beat_acc;
        tag_push.first = beat_acc && (beat_cnt_q == '0);
    end

    dsp_tag_pipe #(
        .DEPTH(TAG_DEPTH)
    ) u_tag_pipe (
        .clk            (clk),
        .rst            (rst),
        .clr_i          (abort_hit),
        .tag_i          (tag_push),
        .valid_o        (dsp_ce_p),
        .opmode_o       (dsp_opmode),
        .upstream_busy_o(pipe_upstream_busy)
    );

    // Job FSM with registered handshake and slice-control outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            len_q         <= '0;
            beat_cnt_q    <= '0;
            start_ready_q <= 1'b1;
            op_ready_q    <= 1'b0;
            res_valid_q   <= 1'b0;
            busy_q        <= 1'b0;
            rst_p_q       <= 1'b0;
        end else begin
            rst_p_q <= 1'b0;
            if (abort_hit) begin
                state_q       <= IDLE;
                beat_cnt_q    <= '0;
                start_ready_q <= 1'b1;
                op_ready_q    <= 1'b0;
                res_valid_q   <= 1'b0;
                busy_q        <= 1'b0;
                rst_p_q       <= 1'b1;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (start_acc) begin
                            start_ready_q <= 1'b0;
                            busy_q        <= 1'b1;
                            beat_cnt_q    <= '0;
                            if (start_len != '0) begin
                                len_q      <= start_len;
                                op_ready_q <= 1'b1;
                                state_q    <= RUN;
                            end else begin
                                // Empty job: clear P once and report zero.
                                rst_p_q <= 1'b1;
                                state_q <= ZERO;
                            end
                        end
                    end
                    RUN: begin
                        if (beat_acc) begin
                            beat_cnt_q <= beat_cnt_d;
                            if (beat_cnt_d == len_q) begin
                                op_ready_q <= 1'b0;
                                state_q    <= DRAIN;
                            end
                        end
                    end
                    ZERO: begin
                        res_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                    DRAIN: begin
                        // When only the output stage may still hold the last
                        // tag, P is final after this edge.
                        if (!pipe_upstream_busy) begin
                            res_valid_q <= 1'b1;
                            state_q     <= DONE;
                        end
                    end
                    DONE: begin
                        if (res_ready) begin
                            res_valid_q   <= 1'b0;
                            busy_q        <= 1'b0;
                            start_ready_q <= 1'b1;
                            state_q       <= IDLE;
                        end
                    end
                    default: begin
                        state_q       <= IDLE;
                        beat_cnt_q    <= '0;
                        start_ready_q <= 1'b1;
                        op_ready_q    <= 1'b0;
                        res_valid_q   <= 1'b0;
                        busy_q        <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign start_ready = start_ready_q;
    assign op_ready    = op_ready_q;
    assign dsp_ce_in   = beat_acc;
    assign dsp_rst_p   = rst_p_q;
    assign res_valid   = res_valid_q;
    assign busy        = busy_q;
    assign beat_cnt    = beat_cnt_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_dsp48a1_mac_sched.sv
// Directed bench for dsp48a1_mac_sched with PIPE_LAT=4. A small behavioural
// slice model (product delay line plus P register driven by the controller's
// CE/OPMODE/RSTP) gives the P value the controller sequence produces.
module tb_dsp48a1_mac_sched;
    import dsp_ctrl_pkg::*;

    localparam int LEN_W = 8;
    localparam int LAT   = 4;

    logic             clk;
    logic             rst;
    logic             start_valid;
    logic             start_ready;
    logic [LEN_W-1:0] start_len;
    logic             op_valid;
    logic             op_ready;
    logic             dsp_ce_in;
    logic             dsp_ce_p;
    logic [7:0]       dsp_opmode;
    logic             dsp_rst_p;
    logic             res_valid;
    logic             res_ready;
    logic             busy;
    logic [LEN_W-1:0] beat_cnt;
    state_e           dbg_state;
`ifdef DSP48A1_MAC_SCHED_ABORT_EN
    logic             abort;
`endif

    logic [15:0] a;
    logic [15:0] b;

    int n_chk  = 0;
    int n_fail = 0;

    dsp48a1_mac_sched #(
        .LEN_W   (LEN_W),
        .PIPE_LAT(LAT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start_valid(start_valid),
        .start_ready(start_ready),
        .start_len  (start_len),
        .op_valid   (op_valid),
        .op_ready   (op_ready),
        .dsp_ce_in  (dsp_ce_in),
        .dsp_ce_p   (dsp_ce_p),
        .dsp_opmode (dsp_opmode),
        .dsp_rst_p  (dsp_rst_p),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .busy       (busy),
        .beat_cnt   (beat_cnt),
`ifdef DSP48A1_MAC_SCHED_ABORT_EN
        .abort      (abort),
`endif
        .dbg_state  (dbg_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Slice model: product captured on dsp_ce_in reaches the P adder
    // LAT-1 cycles later; P loads on dsp_ce_p with Z chosen by OPMODE[3:2].
    logic [31:0] mdl [LAT-1];
    logic [31:0] p_mdl;
    always @(posedge clk) begin
        for (int i = LAT - 2; i > 0; i--) begin
            mdl[i] <= mdl[i-1];
        end
        mdl[0] <= dsp_ce_in ? (32'(a) * 32'(b)) : 32'd0;
        if (dsp_rst_p) begin
            p_mdl <= 32'd0;
        end else if (dsp_ce_p) begin
            p_mdl <= ((dsp_opmode[3:2] == 2'b10) ? p_mdl : 32'd0) + mdl[LAT-2];
        end
    end

    // Event monitor, sampled on the falling edge.
    int         cyc_n       = 0;
    int         ce_p_cnt    = 0;
    int         ce_in_cnt   = 0;
    int         rstp_cnt    = 0;
    int         rv_rises    = 0;
    int         rv_rise_cyc = 0;
    int         beat_cyc    = 0;
    int         rstp_cyc    = 0;
    logic       rv_prev     = 1'b0;
    logic [7:0] opm_log [$];
    always @(negedge clk) begin
        cyc_n   <= cyc_n + 1;
        rv_prev <= res_valid;
        if (dsp_ce_p) begin
            ce_p_cnt <= ce_p_cnt + 1;
            opm_log.push_back(dsp_opmode);
        end
        if (dsp_ce_in) ce_in_cnt <= ce_in_cnt + 1;
        if (op_valid && op_ready) beat_cyc <= cyc_n;
        if (dsp_rst_p) begin
            rstp_cnt <= rstp_cnt + 1;
            rstp_cyc <= cyc_n;
        end
        if (res_valid && !rv_prev) begin
            rv_rises    <= rv_rises + 1;
            rv_rise_cyc <= cyc_n;
        end
    end

    // Watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: observed no end of test, expected finish");
        $fatal(1, "watchdog expired");
    end

    // Driver / checker tasks
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
        #1;
    endtask

    task automatic start_job(input int len);
        start_valid = 1'b1;
        start_len   = LEN_W'(len);
        step();
        start_valid = 1'b0;
    endtask

    task automatic beat(input int x, input int y);
        op_valid = 1'b1;
        a        = 16'(x);
        b        = 16'(y);
        step();
        op_valid = 1'b0;
    endtask

    task automatic wait_res(input int bound);
        for (int i = 0; i < bound; i++) begin
            smp();
            if (res_valid) break;
        end
        chk("res_valid_timeout", 32'(res_valid), 32'd1);
    endtask

    task automatic finish_job();
        step();
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
    endtask

    int base_cep;
    int base_cein;
    int base_rstp;
    int base_rv;
    int base_opm;

    initial begin
        rst         = 1'b1;
        start_valid = 1'b0;
        start_len   = '0;
        op_valid    = 1'b0;
        a           = '0;
        b           = '0;
        res_ready   = 1'b0;
`ifdef DSP48A1_MAC_SCHED_ABORT_EN
        abort       = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;

        // Reset values
        smp();
        chk("rst_start_ready", 32'(start_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_op_ready", 32'(op_ready), 32'd0);
        chk("rst_ce_in", 32'(dsp_ce_in), 32'd0);
        chk("rst_ce_p", 32'(dsp_ce_p), 32'd0);
        chk("rst_rst_p", 32'(dsp_rst_p), 32'd0);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_opmode", 32'(dsp_opmode), 32'h01);
        chk("rst_beat_cnt", 32'(beat_cnt), 32'd0);
        chk("rst_state", 32'(dbg_state), 32'(IDLE));
        step();
        rst = 1'b0;

        // Reset in the middle of RUN after two beats
        start_job(5);
        beat(1, 1);
        beat(1, 1);
        smp();
        chk("midrst_beats_before", 32'(beat_cnt), 32'd2);
        chk("midrst_busy_before", 32'(busy), 32'd1);
        step();
        base_rv = rv_rises;
        rst = 1'b1;
        smp();
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_start_ready", 32'(start_ready), 32'd1);
        chk("midrst_ce_p", 32'(dsp_ce_p), 32'd0);
        chk("midrst_beat_cnt", 32'(beat_cnt), 32'd0);
        step();
        rst = 1'b0;
        repeat (10) step();
        smp();
        chk("midrst_no_result", 32'(rv_rises - base_rv), 32'd0);
        chk("midrst_idle", 32'(dbg_state), 32'(IDLE));
        step();

        // len=3 back-to-back: 2*3 + 4*5 + 6*7 = 68
        base_cep = ce_p_cnt;
        base_opm = opm_log.size();
        start_job(3);
        beat(2, 3);
        beat(4, 5);
        beat(6, 7);
        wait_res(20);
        chk("len3_latency", 32'(rv_rise_cyc - beat_cyc), 32'd4);
        chk("len3_ce_p_count", 32'(ce_p_cnt - base_cep), 32'd3);
        chk("len3_opmode0", 32'(opm_log[base_opm]), 32'h01);
        chk("len3_opmode1", 32'(opm_log[base_opm + 1]), 32'h09);
        chk("len3_opmode2", 32'(opm_log[base_opm + 2]), 32'h09);
        chk("len3_p", p_mdl, 32'd68);
        chk("len3_beat_cnt", 32'(beat_cnt), 32'd3);
        chk("len3_start_ready", 32'(start_ready), 32'd0);
        finish_job();

        // len=4 with two bubble cycles: 1*2 + 3*4 + 5*6 + 7*8 = 100
        base_cep  = ce_p_cnt;
        base_cein = ce_in_cnt;
        base_opm  = opm_log.size();
        start_job(4);
        beat(1, 2);
        beat(3, 4);
        step();
        step();
        beat(5, 6);
        beat(7, 8);
        wait_res(20);
        chk("bub_ce_p_count", 32'(ce_p_cnt - base_cep), 32'd4);
        chk("bub_ce_in_count", 32'(ce_in_cnt - base_cein), 32'd4);
        chk("bub_opmode0", 32'(opm_log[base_opm]), 32'h01);
        chk("bub_opmode3", 32'(opm_log[base_opm + 3]), 32'h09);
        chk("bub_p", p_mdl, 32'd100);
        finish_job();

        // len=0: single P clear, result one cycle after it
        base_cein = ce_in_cnt;
        base_rstp = rstp_cnt;
        start_job(0);
        wait_res(10);
        chk("zero_rst_p_pulses", 32'(rstp_cnt - base_rstp), 32'd1);
        chk("zero_rv_after_rst_p", 32'(rv_rise_cyc - rstp_cyc), 32'd1);
        chk("zero_ce_in_count", 32'(ce_in_cnt - base_cein), 32'd0);
        chk("zero_p", p_mdl, 32'd0);
        finish_job();

        // DONE held for 5 cycles with a start pending: 9*9 + 10*10 = 181
        start_job(2);
        beat(9, 9);
        beat(10, 10);
        wait_res(20);
        step();
        start_valid = 1'b1;
        start_len   = LEN_W'(1);
        for (int k = 0; k < 5; k++) begin
            smp();
            chk("hold_res_valid", 32'(res_valid), 32'd1);
            chk("hold_start_ready", 32'(start_ready), 32'd0);
            chk("hold_p", p_mdl, 32'd181);
            chk("hold_state", 32'(dbg_state), 32'(DONE));
            step();
        end
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        smp();
        chk("hold_back_idle", 32'(dbg_state), 32'(IDLE));
        chk("hold_idle_ready", 32'(start_ready), 32'd1);
        step();
        start_valid = 1'b0;
        smp();
        chk("hold_new_job_run", 32'(dbg_state), 32'(RUN));
        chk("hold_new_job_cnt", 32'(beat_cnt), 32'd0);
        step();
        beat(3, 3);
        wait_res(20);
        chk("hold_new_job_p", p_mdl, 32'd9);
        finish_job();

        // Maximum length: 255 beats of 1*1
        base_cep = ce_p_cnt;
        start_job(255);
        op_valid = 1'b1;
        a        = 16'd1;
        b        = 16'd1;
        repeat (255) step();
        op_valid = 1'b0;
        wait_res(20);
        chk("max_beat_cnt", 32'(beat_cnt), 32'd255);
        chk("max_ce_p_count", 32'(ce_p_cnt - base_cep), 32'd255);
        chk("max_p", p_mdl, 32'd255);
        finish_job();

`ifdef DSP48A1_MAC_SCHED_ABORT_EN
        // Abort while draining a len=2 job
        start_job(2);
        beat(2, 2);
        beat(3, 3);
        base_rv   = rv_rises;
        base_rstp = rstp_cnt;
        abort = 1'b1;
        step();
        abort = 1'b0;
        smp();
        chk("abort_idle", 32'(dbg_state), 32'(IDLE));
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_rst_p", 32'(dsp_rst_p), 32'd1);
        chk("abort_ce_p", 32'(dsp_ce_p), 32'd0);
        chk("abort_beat_cnt", 32'(beat_cnt), 32'd0);
        step();
        repeat (8) step();
        smp();
        chk("abort_no_result", 32'(rv_rises - base_rv), 32'd0);
        chk("abort_rst_p_pulses", 32'(rstp_cnt - base_rstp), 32'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
